axi4_stream_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter/mux that shares one AXI4-Stream datapath (e.g. a width downsizer) between NUM_INPUTS requesters.
- Grants a single source for a whole packet and releases it on the output tlast handshake, so packets are never interleaved.
- Sits upstream of the shared stream resource. Exposes grant and busy status for debug and for software-visible counters.

---
 rtl/axi4_stream_rr_arbiter_if.sv | 20 ++
 rtl/axi4_stream_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_axi4_stream_rr_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_rr_arbiter_if.sv
// AXI4-Stream bundle used for the arbiter's requester ports and its shared output.
interface axi4_stream_if #(
   parameter int TDATA_WIDTH = 32,
   parameter int TUSER_WIDTH = 8,
   parameter int TDEST_WIDTH = 4,
   parameter int TID_WIDTH   = 4
);
   logic                     tvalid;
   logic                     tready;
   logic [TDATA_WIDTH-1:0]   tdata;
   logic [TDATA_WIDTH/8-1:0] tstrb;
   logic [TDATA_WIDTH/8-1:0] tkeep;
   logic                     tlast;
   logic [TUSER_WIDTH-1:0]   tuser;
   logic [TDEST_WIDTH-1:0]   tdest;
   logic [TID_WIDTH-1:0]     tid;

   modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid, input tready);
   modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid, output tready);
endinterface

// File: rtl/axi4_stream_rr_arbiter.sv
// Packet-granular round-robin mux: one source owns the output from grant until its
// tlast handshake, then the pointer moves past it.
module axi4_stream_rr_arbiter #(
   parameter int  NUM_INPUTS  = 4,
   parameter int  TDATA_WIDTH = 32,
   parameter int  TUSER_WIDTH = 8,
   parameter int  TDEST_WIDTH = 4,
   parameter int  TID_WIDTH   = 4,
   localparam int PTR_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [NUM_INPUTS-1:0] en_mask_i,
   axi4_stream_if.slave          pkt_i [NUM_INPUTS],
   axi4_stream_if.master         pkt_o,
   output logic [NUM_INPUTS-1:0] grant_o,
   output logic                  busy_o
);
   localparam int                 KW    = TDATA_WIDTH / 8;
   localparam logic [PTR_WIDTH:0] NUM_W = (PTR_WIDTH + 1)'(NUM_INPUTS);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e                 state_q, state_d;
   logic [NUM_INPUTS-1:0]  grant_q, grant_d;
   logic [PTR_WIDTH-1:0]   gidx_q, gidx_d;
   logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;

   logic [NUM_INPUTS-1:0]  vld_a, last_a, req;
   logic [TDATA_WIDTH-1:0] data_a [NUM_INPUTS];
   logic [KW-1:0]          strb_a [NUM_INPUTS];
   logic [KW-1:0]          keep_a [NUM_INPUTS];
   logic [TUSER_WIDTH-1:0] user_a [NUM_INPUTS];
   logic [TDEST_WIDTH-1:0] dest_a [NUM_INPUTS];
   logic [TID_WIDTH-1:0]   id_a   [NUM_INPUTS];

   logic [TDATA_WIDTH-1:0] o_data;
   logic [KW-1:0]          o_strb, o_keep;
   logic [TUSER_WIDTH-1:0] o_user;
   logic [TDEST_WIDTH-1:0] o_dest;
   logic [TID_WIDTH-1:0]   o_id;

   logic                   sel_found;
   logic [PTR_WIDTH-1:0]   sel_idx;
   logic [PTR_WIDTH:0]     scan, nxt;
   logic                   release_hs;

   for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_in
      assign vld_a[k]        = pkt_i[k].tvalid;
      assign last_a[k]       = pkt_i[k].tlast;
      assign data_a[k]       = pkt_i[k].tdata;
      assign strb_a[k]       = pkt_i[k].tstrb;
      assign keep_a[k]       = pkt_i[k].tkeep;
      assign user_a[k]       = pkt_i[k].tuser;
      assign dest_a[k]       = pkt_i[k].tdest;
      assign id_a[k]         = pkt_i[k].tid;
      // grant_q is all-zero in IDLE, so no source sees tready outside its packet
      assign pkt_i[k].tready = grant_q[k] & pkt_o.tready;
   end

   assign req = vld_a & en_mask_i;

   // Grant is one-hot, so an OR of masked fields is the mux
   always_comb begin
      o_data = '0;
      o_strb = '0;
      o_keep = '0;
      o_user = '0;
      o_dest = '0;
      o_id   = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (grant_q[k]) begin
            o_data |= data_a[k];
            o_strb |= strb_a[k];
            o_keep |= keep_a[k];
            o_user |= user_a[k];
            o_dest |= dest_a[k];
            o_id   |= id_a[k];
         end
      end
   end

   assign pkt_o.tvalid = |(grant_q & vld_a);
   assign pkt_o.tlast  = |(grant_q & last_a);
   assign pkt_o.tdata  = o_data;
   assign pkt_o.tstrb  = o_strb;
   assign pkt_o.tkeep  = o_keep;
   assign pkt_o.tuser  = o_user;
   assign pkt_o.tdest  = o_dest;
   assign pkt_o.tid    = o_id;

   // Scan ptr, ptr+1, ... wrapping at NUM_INPUTS rather than at 2^PTR_WIDTH
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan      = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         scan = {1'b0, ptr_q} + (PTR_WIDTH + 1)'(i);
         if (scan >= NUM_W) scan = scan - NUM_W;
         if (!sel_found && req[scan[PTR_WIDTH-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = scan[PTR_WIDTH-1:0];
         end
      end
   end

   assign release_hs = pkt_o.tvalid & pkt_o.tready & pkt_o.tlast;
   assign nxt        = {1'b0, gidx_q} + (PTR_WIDTH + 1)'(1);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: if (sel_found) begin
            state_d = BUSY;
            grant_d = NUM_INPUTS'(1) << sel_idx;
            gidx_d  = sel_idx;
         end
         BUSY: if (release_hs) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = (nxt >= NUM_W) ? '0 : nxt[PTR_WIDTH-1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant_o = grant_q;
   assign busy_o  = (state_q == BUSY);
endmodule

// File: tb/tb_axi4_stream_rr_arbiter.sv
// Random and directed stimulus against an owner/pointer model of the packet arbiter,
// plus a single-input 64-bit instance for the degenerate configuration.
module tb_axi4_stream_rr_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n     = 1'b0;
   logic [N-1:0] en_mask   = '1;
   logic         out_ready = 1'b0;
   logic [N-1:0] s_valid   = '0;
   logic [N-1:0] s_last    = '0;
   logic [N-1:0] s_ready;
   logic [31:0]  s_data [N];
   logic [3:0]   s_strb [N];
   logic [3:0]   s_keep [N];
   logic [7:0]   s_user [N];
   logic [3:0]   s_dest [N];
   logic [3:0]   s_id   [N];
   logic [N-1:0] grant;
   logic         busy;

   axi4_stream_if #(.TDATA_WIDTH(32)) in_if [N] ();
   axi4_stream_if #(.TDATA_WIDTH(32)) out_if ();

   for (genvar k = 0; k < N; k++) begin : g_src
      assign in_if[k].tvalid = s_valid[k];
      assign in_if[k].tdata  = s_data[k];
      assign in_if[k].tstrb  = s_strb[k];
      assign in_if[k].tkeep  = s_keep[k];
      assign in_if[k].tlast  = s_last[k];
      assign in_if[k].tuser  = s_user[k];
      assign in_if[k].tdest  = s_dest[k];
      assign in_if[k].tid    = s_id[k];
      assign s_ready[k]      = in_if[k].tready;
   end
   assign out_if.tready = out_ready;

   axi4_stream_rr_arbiter #(.NUM_INPUTS(N), .TDATA_WIDTH(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .en_mask_i(en_mask),
      .pkt_i(in_if), .pkt_o(out_if), .grant_o(grant), .busy_o(busy));

   // Single-input, 64-bit instance
   logic        d2_valid = 1'b0, d2_last = 1'b0, d2_ready;
   logic [63:0] d2_data = '0;
   logic [7:0]  d2_keep = '0, d2_strb = '0, d2_user = '0;
   logic [0:0]  d2_grant;
   logic        d2_busy;

   axi4_stream_if #(.TDATA_WIDTH(64)) in2_if [1] ();
   axi4_stream_if #(.TDATA_WIDTH(64)) out2_if ();
   assign in2_if[0].tvalid = d2_valid;
   assign in2_if[0].tdata  = d2_data;
   assign in2_if[0].tstrb  = d2_strb;
   assign in2_if[0].tkeep  = d2_keep;
   assign in2_if[0].tlast  = d2_last;
   assign in2_if[0].tuser  = d2_user;
   assign in2_if[0].tdest  = 4'h3;
   assign in2_if[0].tid    = 4'h5;
   assign d2_ready         = in2_if[0].tready;
   assign out2_if.tready   = 1'b1;

   axi4_stream_rr_arbiter #(.NUM_INPUTS(1), .TDATA_WIDTH(64)) dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .en_mask_i(1'b1),
      .pkt_i(in2_if), .pkt_o(out2_if), .grant_o(d2_grant), .busy_o(d2_busy));

   int total = 0, bad = 0, cyc = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endfunction

   typedef struct { int src; int seq; int beat; logic last; int cyc; } beat_t;
   typedef struct { logic [63:0] d; logic [7:0] keep; logic [7:0] strb; logic [7:0] user; logic last; int cyc; } d2_t;
   beat_t        bl[$];
   int           gl[$], gcyc[$];
   d2_t          d2q[$], d2exp[$], d2l[$];
   logic [N-1:0] prev_grant = '0;

   // Model: who owns the output (-1 = nobody) and where the next scan starts
   int m_owner = -1, m_ptr = 0;

   always @(negedge clk) begin : cmp
      logic [N-1:0] eg, er;
      logic         ev;
      int           k2;
      cyc++;
      if (!rst_n) begin
         m_owner = -1;
         m_ptr   = 0;
         chk("rst_grant", grant, 0);
         chk("rst_busy", busy, 0);
         chk("rst_tvalid", out_if.tvalid, 0);
         chk("rst_tready", s_ready, 0);
      end else begin
         eg = '0;
         ev = 1'b0;
         if (m_owner >= 0) begin
            eg = N'(1) << m_owner;
            ev = s_valid[m_owner];
         end
         er = out_ready ? eg : '0;
         chk("grant", grant, eg);
         chk("busy", busy, m_owner >= 0);
         chk("tvalid", out_if.tvalid, ev);
         chk("tready", s_ready, er);
         if (ev) begin
            chk("tdata", out_if.tdata, s_data[m_owner]);
            chk("tstrb", out_if.tstrb, s_strb[m_owner]);
            chk("tkeep", out_if.tkeep, s_keep[m_owner]);
            chk("tlast", out_if.tlast, s_last[m_owner]);
            chk("tuser", out_if.tuser, s_user[m_owner]);
            chk("tdest", out_if.tdest, s_dest[m_owner]);
            chk("tid", out_if.tid, s_id[m_owner]);
         end
         if (out_if.tvalid && out_ready)
            bl.push_back('{int'(out_if.tdata[31:24]), int'(out_if.tdata[23:16]),
                           int'(out_if.tdata[15:0]), out_if.tlast, cyc});
         if (grant != '0 && prev_grant == '0)
            for (int k = 0; k < N; k++) if (grant[k]) begin gl.push_back(k); gcyc.push_back(cyc); end
         if (out2_if.tvalid)
            d2l.push_back('{out2_if.tdata, out2_if.tkeep, out2_if.tstrb, out2_if.tuser, out2_if.tlast, cyc});
         if (m_owner >= 0) begin
            if (ev && out_ready && s_last[m_owner]) begin
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
            end
         end else begin
            for (int off = 0; off < N; off++) begin
               k2 = (m_ptr + off) % N;
               if (m_owner < 0 && s_valid[k2] && en_mask[k2]) m_owner = k2;
            end
         end
      end
      prev_grant = grant;
   end

   // Requester sources: npkt packets of plen beats (0 = random 1..4); tdata = {src, seq, beat}
   int npkt[N], plen[N], beat_i[N], clen[N], seq_i[N];
   int stall_pct = 0, rdy_mode = 0;

   task automatic clr_src();
      for (int k = 0; k < N; k++) begin
         npkt[k] = 0; plen[k] = 0; beat_i[k] = 0; clen[k] = 0; seq_i[k] = 0;
         s_valid[k] = 1'b0; s_last[k] = 1'b0; s_data[k] = '0; s_strb[k] = '0;
         s_keep[k] = '0; s_user[k] = '0; s_dest[k] = '0; s_id[k] = '0;
      end
      d2q.delete();
      d2_valid = 1'b0;
   endtask

   task automatic src_update(input logic [N-1:0] hs);
      for (int k = 0; k < N; k++) begin
         if (hs[k]) begin
            s_valid[k] = 1'b0;
            if (s_last[k]) begin npkt[k]--; seq_i[k]++; beat_i[k] = 0; clen[k] = 0; end
            else beat_i[k]++;
         end
         if (!s_valid[k] && npkt[k] > 0 && int'($urandom_range(99)) >= stall_pct) begin
            if (clen[k] == 0) clen[k] = (plen[k] > 0) ? plen[k] : int'($urandom_range(4, 1));
            s_valid[k] = 1'b1;
            s_data[k]  = {8'(k), 8'(seq_i[k]), 16'(beat_i[k])};
            s_last[k]  = (beat_i[k] == clen[k] - 1);
            s_strb[k]  = 4'($urandom);
            s_keep[k]  = 4'($urandom);
            s_user[k]  = 8'($urandom);
            s_dest[k]  = 4'($urandom);
            s_id[k]    = 4'($urandom);
         end
      end
   endtask

   task automatic d2_update(input logic hs2);
      d2_t e;
      if (hs2) begin d2_valid = 1'b0; void'(d2q.pop_front()); end
      if (!d2_valid && d2q.size() > 0) begin
         e = d2q[0];
         d2_valid = 1'b1; d2_data = e.d; d2_keep = e.keep; d2_strb = e.strb;
         d2_user = e.user; d2_last = e.last;
      end
   endtask

   task automatic step();
      logic [N-1:0] hs;
      logic         hs2;
      @(negedge clk); #1;
      hs  = s_valid & s_ready;
      hs2 = d2_valid & d2_ready;
      @(posedge clk); #1;
      src_update(hs);
      d2_update(hs2);
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(1));
      endcase
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      clr_src();
      stall_pct = 0; rdy_mode = 0; out_ready = 1'b1; en_mask = '1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bl.delete(); gl.delete(); gcyc.delete(); d2l.delete();
   endtask

   int c0, n2, lens[3] = '{1, 1, 7};
   logic hit;

   initial begin
      clr_src();

      // T1: four simultaneous 3-beat packets, sink always ready
      apply_reset();
      for (int k = 0; k < N; k++) begin npkt[k] = 1; plen[k] = 3; end
      step();
      c0 = cyc + 1;
      repeat (30) step();
      chk("t1_ngrant", gl.size(), 4);
      for (int i = 0; i < 4 && i < gl.size(); i++) chk($sformatf("t1_grant%0d", i), gl[i], i);
      if (gcyc.size() > 0) chk("t1_bubble", gcyc[0] - c0, 1);
      chk("t1_nbeats", bl.size(), 12);
      if (bl.size() == 12) begin
         chk("t1_span", bl[11].cyc - bl[0].cyc, 14);
         chk("t1_first_beat", bl[0].cyc - gcyc[0], 0);
         for (int p = 0; p < 3; p++) chk($sformatf("t1_gap%0d", p), bl[3*p+3].cyc - bl[3*p+2].cyc, 2);
         for (int i = 0; i < 12; i++) chk($sformatf("t1_beat%0d", i), {bl[i].src, bl[i].beat}, {i / 3, i % 3});
      end

      // T2: inputs 1 and 3 backlogged alternate
      apply_reset();
      npkt[1] = 1000; npkt[3] = 1000;
      repeat (120) step();
      chk("t2_enough", gl.size() >= 8, 1);
      for (int i = 0; i < gl.size(); i++) chk($sformatf("t2_grant%0d", i), gl[i], (i % 2) ? 3 : 1);

      // T3: input 2 4-beat packet under toggling tready; input 0 arrives mid-packet
      apply_reset();
      rdy_mode = 1; npkt[2] = 1; plen[2] = 4; plen[0] = 2;
      for (int i = 0; i < 40; i++) begin
         step();
         if (beat_i[2] == 2 && npkt[0] == 0 && seq_i[0] == 0) npkt[0] = 1;
      end
      chk("t3_ngrant", gl.size(), 2);
      chk("t3_nbeats", bl.size(), 6);
      if (gl.size() == 2 && bl.size() == 6) begin
         chk("t3_g0", gl[0], 2);
         chk("t3_g1", gl[1], 0);
         for (int i = 0; i < 6; i++)
            chk($sformatf("t3_beat%0d", i), {bl[i].src, bl[i].beat}, (i < 4) ? {2, i} : {0, i - 4});
         chk("t3_after_tlast", gcyc[1] - bl[3].cyc, 2);
      end

      // T4: mask 0101, then drop bit 2 while input 2 is mid-packet
      apply_reset();
      en_mask = 4'b0101;
      npkt[0] = 3; npkt[1] = 1000; npkt[2] = 1; npkt[3] = 1000;
      for (int k = 0; k < N; k++) plen[k] = 3;
      for (int i = 0; i < 60; i++) begin
         step();
         if (en_mask == 4'b0101 && beat_i[2] == 1) en_mask = 4'b0001;
      end
      chk("t4_ngrant", gl.size(), 4);
      for (int i = 0; i < 4 && i < gl.size(); i++) chk($sformatf("t4_grant%0d", i), gl[i], (i == 1) ? 2 : 0);
      n2 = 0;
      foreach (bl[i]) if (bl[i].src == 2) n2++;
      chk("t4_in2_beats", n2, 3);

      // T5: reset pulse during beat 2 of a 5-beat packet; pointer must restart at 0
      apply_reset();
      npkt[1] = 1; plen[1] = 1;
      repeat (6) step();
      npkt[0] = 1; plen[0] = 5;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         step();
         if (beat_i[0] == 2) hit = 1'b1;
      end
      chk("t5_reached_beat2", hit, 1);
      chk("t5_busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_tvalid", out_if.tvalid, 0);
      chk("t5_async_grant", grant, 0);
      chk("t5_async_busy", busy, 0);
      clr_src();
      @(posedge clk);
      #1 rst_n = 1'b1;
      bl.delete(); gl.delete(); gcyc.delete();
      for (int k = 0; k < N; k++) begin npkt[k] = 1; plen[k] = 1; end
      repeat (20) step();
      chk("t5_ngrant", gl.size(), 4);
      for (int i = 0; i < 4 && i < gl.size(); i++) chk($sformatf("t5_grant%0d", i), gl[i], i);

      // T6: single-input 64-bit instance, packets of 1, 1 and 7 beats
      apply_reset();
      d2exp.delete();
      for (int p = 0; p < 3; p++)
         for (int b = 0; b < lens[p]; b++) begin
            d2_t e;
            e.d = {$urandom, $urandom}; e.keep = 8'($urandom); e.strb = 8'($urandom);
            e.user = 8'($urandom); e.last = (b == lens[p] - 1); e.cyc = 0;
            d2q.push_back(e);
            d2exp.push_back(e);
         end
      repeat (30) step();
      chk("t6_nbeats", d2l.size(), 9);
      if (d2l.size() == 9) begin
         for (int i = 0; i < 9; i++) begin
            chk($sformatf("t6_data%0d", i), d2l[i].d, d2exp[i].d);
            chk($sformatf("t6_keep%0d", i), d2l[i].keep, d2exp[i].keep);
            chk($sformatf("t6_user%0d", i), d2l[i].user, d2exp[i].user);
            chk($sformatf("t6_last%0d", i), d2l[i].last, d2exp[i].last);
         end
         chk("t6_gap0", d2l[1].cyc - d2l[0].cyc, 2);
         chk("t6_gap1", d2l[2].cyc - d2l[1].cyc, 2);
         for (int i = 2; i < 8; i++) chk($sformatf("t6_run%0d", i), d2l[i+1].cyc - d2l[i].cyc, 1);
      end

      // Random: stalls, random sink ready, mask changes
      apply_reset();
      stall_pct = 30; rdy_mode = 2;
      for (int k = 0; k < N; k++) npkt[k] = 1000;
      for (int i = 0; i < 1500; i++) begin
         if (i % 25 == 0) en_mask = 4'($urandom);
         step();
      end
      chk("rnd_enough", gl.size() > 50, 1);
      for (int i = 1; i < bl.size(); i++)
         if (!bl[i-1].last)
            chk($sformatf("rnd_contig%0d", i), {bl[i].src, bl[i].beat}, {bl[i-1].src, bl[i-1].beat + 1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
